// File: rtl/sync_fifo_w_ocup_th.sv
// sync_fifo_w_ocup_th: single-clock FIFO of any depth with occupancy, free count, thresholds and flush; SYNC_FIFO_ERR_FLAGS_EN adds sticky ovf/udf flags
module sync_fifo_w_ocup_th #(
  parameter int SLOTS = 4,
  parameter int WIDTH = 8,
  parameter int AFULL_TH = SLOTS - 1,
  parameter int AEMPTY_TH = 1,
  localparam int CW = $clog2(SLOTS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             wr_full_o,
  output logic             wr_afull_o,
  output logic [CW-1:0]    free_o,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_empty_o,
  output logic             rd_aempty_o,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  input  logic             err_clr_i,
  output logic             ovf_o,
  output logic             udf_o,
`endif
  output logic [CW-1:0]    ocup_o
);
  localparam int PW = $clog2(SLOTS);
  logic [WIDTH-1:0] mem_q [SLOTS];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic wa, ra;
  assign wr_full_o   = cnt_q == CW'(SLOTS);
  assign rd_empty_o  = cnt_q == '0;
  assign wr_afull_o  = cnt_q >= CW'(AFULL_TH);
  assign rd_aempty_o = cnt_q <= CW'(AEMPTY_TH);
  assign free_o      = CW'(SLOTS) - cnt_q;
  assign ocup_o      = cnt_q;
  assign rd_data_o   = mem_q[rd_ptr_q];
  // Accepted requests and next pointer/count; flush discards everything and wins over both requests
  always_comb begin
    wa = wr_en_i & ~wr_full_o & ~flush_i;
    ra = rd_en_i & ~rd_empty_o & ~flush_i;
    wr_ptr_d = flush_i ? '0 : !wa ? wr_ptr_q : wr_ptr_q == PW'(SLOTS - 1) ? '0 : wr_ptr_q + 1'b1;
    rd_ptr_d = flush_i ? '0 : !ra ? rd_ptr_q : rd_ptr_q == PW'(SLOTS - 1) ? '0 : rd_ptr_q + 1'b1;
    cnt_d = flush_i ? '0 : (wa & ~ra) ? cnt_q + 1'b1 : (ra & ~wa) ? cnt_q - 1'b1 : cnt_q;
  end
  // Pointer and count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
  // Storage has no reset; stale contents are hidden behind the count
  always_ff @(posedge clk) begin
    if (wa) mem_q[wr_ptr_q] <= wr_data_i;
  end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic ovf_q, udf_q;
  assign ovf_o = ovf_q;
  assign udf_o = udf_q;
  // Sticky error flags; a new offence in the same cycle beats the clear
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= (wr_en_i & wr_full_o & ~flush_i) | (ovf_q & ~err_clr_i);
      udf_q <= (rd_en_i & rd_empty_o & ~flush_i) | (udf_q & ~err_clr_i);
    end
  end
`else
`endif
`ifndef NO_ASSERTIONS
  param_legal_a: assert property (@(posedge clk)
    SLOTS >= 2 && AFULL_TH >= 1 && AFULL_TH <= SLOTS && AEMPTY_TH >= 0 && AEMPTY_TH < SLOTS);
  cnt_range_a: assert property (@(posedge clk) disable iff (rst) cnt_q <= CW'(SLOTS));
  free_ocup_a: assert property (@(posedge clk) disable iff (rst) int'(free_o) + int'(ocup_o) == SLOTS);
`endif
endmodule

// File: tb/tb_sync_fifo_w_ocup_th.sv
// tb_sync_fifo_w_ocup_th: directed and randomized checks of the FIFO against a queue model
module tb_sync_fifo_w_ocup_th;
  localparam int SLOTS = 5;
  localparam int CW = 3;
  logic clk = 1'b0;
  logic rst = 1'b1, flush_i = 1'b0, wr_en_i = 1'b0, rd_en_i = 1'b0;
  logic [7:0] wr_data_i = '0;
  logic wr_full_o, wr_afull_o, rd_empty_o, rd_aempty_o;
  logic [CW-1:0] free_o, ocup_o;
  logic [7:0] rd_data_o;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic err_clr_i = 1'b0, ovf_o, udf_o;
  bit ovf_m, udf_m;
`endif
  int checks = 0, errors = 0;
  logic [7:0] q [$];
  always #5 clk = ~clk;
  sync_fifo_w_ocup_th #(.SLOTS(5), .WIDTH(8), .AFULL_TH(4), .AEMPTY_TH(1)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .wr_en_i(wr_en_i), .wr_data_i(wr_data_i),
    .wr_full_o(wr_full_o), .wr_afull_o(wr_afull_o), .free_o(free_o), .rd_en_i(rd_en_i),
    .rd_data_o(rd_data_o), .rd_empty_o(rd_empty_o), .rd_aempty_o(rd_aempty_o),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    .err_clr_i(err_clr_i), .ovf_o(ovf_o), .udf_o(udf_o),
`endif
    .ocup_o(ocup_o));

  task automatic step(input bit w, input logic [7:0] d, input bit r, input bit f = 0, input bit rs = 0, input bit c = 0);
    bit pre_full, pre_empty;
    wr_en_i = w; wr_data_i = d; rd_en_i = r; flush_i = f; rst = rs;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    err_clr_i = c;
`endif
    pre_full = q.size() == SLOTS;
    pre_empty = q.size() == 0;
    @(posedge clk);
    if (rs || f) q.delete();
    else begin
      if (r && !pre_empty) void'(q.pop_front());
      if (w && !pre_full) q.push_back(d);
    end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ovf_m = rs ? 1'b0 : (w && pre_full && !f) ? 1'b1 : c ? 1'b0 : ovf_m;
    udf_m = rs ? 1'b0 : (r && pre_empty && !f) ? 1'b1 : c ? 1'b0 : udf_m;
`else
    if (c) begin end
`endif
    #1;
    wr_en_i = 0; rd_en_i = 0; flush_i = 0; rst = 0;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    err_clr_i = 0;
`endif
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0);
    checks += 6;
    if (ocup_o !== 3'd0) begin errors++; $display("FAIL reset_ocup: got %0d exp 0", ocup_o); end
    if (free_o !== 3'd5) begin errors++; $display("FAIL reset_free: got %0d exp 5", free_o); end
    if (rd_empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b exp 1", rd_empty_o); end
    if (rd_aempty_o !== 1'b1) begin errors++; $display("FAIL reset_aempty: got %b exp 1", rd_aempty_o); end
    if (wr_full_o !== 1'b0) begin errors++; $display("FAIL reset_full: got %b exp 0", wr_full_o); end
    if (wr_afull_o !== 1'b0) begin errors++; $display("FAIL reset_afull: got %b exp 0", wr_afull_o); end
  endtask

  task automatic test_fill();
    for (int k = 1; k <= 5; k++) begin
      step(1, 8'(k * 17), 0);
      if (k == 4) begin
        checks += 2;
        if (wr_afull_o !== 1'b1) begin errors++; $display("FAIL fill_afull: got %b exp 1", wr_afull_o); end
        if (wr_full_o !== 1'b0) begin errors++; $display("FAIL fill_full4: got %b exp 0", wr_full_o); end
      end
    end
    checks += 3;
    if (wr_full_o !== 1'b1) begin errors++; $display("FAIL fill_full: got %b exp 1", wr_full_o); end
    if (ocup_o !== 3'd5) begin errors++; $display("FAIL fill_ocup: got %0d exp 5", ocup_o); end
    if (free_o !== 3'd0) begin errors++; $display("FAIL fill_free: got %0d exp 0", free_o); end
    step(1, 8'h66, 0);
    checks += 2;
    if (ocup_o !== 3'd5) begin errors++; $display("FAIL ovf_ocup: got %0d exp 5", ocup_o); end
    if (rd_data_o !== 8'h11) begin errors++; $display("FAIL ovf_head: got %h exp 11", rd_data_o); end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    checks++;
    if (ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b exp 1", ovf_o); end
`endif
  endtask

  task automatic test_full_both();
    step(1, 8'h77, 1);
    checks += 2;
    if (ocup_o !== 3'd4) begin errors++; $display("FAIL fullboth_ocup: got %0d exp 4", ocup_o); end
    if (rd_data_o !== 8'h22) begin errors++; $display("FAIL fullboth_head: got %h exp 22", rd_data_o); end
    for (int k = 2; k <= 5; k++) begin
      checks++;
      if (rd_data_o !== 8'(k * 17)) begin errors++; $display("FAIL drain_data: got %h exp %h", rd_data_o, 8'(k * 17)); end
      step(0, 0, 1);
    end
    checks++;
    if (rd_empty_o !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b exp 1", rd_empty_o); end
  endtask

  task automatic test_empty_both();
    step(1, 8'h99, 1);
    checks += 3;
    if (ocup_o !== 3'd1) begin errors++; $display("FAIL emptyboth_ocup: got %0d exp 1", ocup_o); end
    if (rd_empty_o !== 1'b0) begin errors++; $display("FAIL emptyboth_empty: got %b exp 0", rd_empty_o); end
    if (rd_data_o !== 8'h99) begin errors++; $display("FAIL emptyboth_data: got %h exp 99", rd_data_o); end
    step(0, 0, 1);
  endtask

  task automatic test_wrap();
    step(1, 8'hA0, 0);
    for (int k = 1; k <= 6; k++) begin
      checks++;
      if (rd_data_o !== 8'(8'hA0 + k - 1)) begin errors++; $display("FAIL wrap_pop: got %h exp %h", rd_data_o, 8'(8'hA0 + k - 1)); end
      step(1, 8'(8'hA0 + k), 1);
      checks++;
      if (ocup_o !== 3'd1) begin errors++; $display("FAIL wrap_ocup: got %0d exp 1", ocup_o); end
    end
    checks++;
    if (rd_data_o !== 8'hA6) begin errors++; $display("FAIL wrap_last: got %h exp a6", rd_data_o); end
    step(0, 0, 1);
  endtask

  task automatic test_flush();
    for (int k = 1; k <= 3; k++) step(1, 8'(8'h30 + k), 0);
    checks++;
    if (ocup_o !== 3'd3) begin errors++; $display("FAIL flush_pre: got %0d exp 3", ocup_o); end
    step(1, 8'h3F, 0, 1);
    checks += 2;
    if (ocup_o !== 3'd0) begin errors++; $display("FAIL flush_ocup: got %0d exp 0", ocup_o); end
    if (rd_empty_o !== 1'b1) begin errors++; $display("FAIL flush_empty: got %b exp 1", rd_empty_o); end
    step(0, 0, 0);
    checks++;
    if (ocup_o !== 3'd0) begin errors++; $display("FAIL flush_nostore: got %0d exp 0", ocup_o); end
  endtask

  task automatic test_mid_reset();
    step(1, 8'h41, 0);
    step(1, 8'h42, 0);
    step(1, 8'h43, 1, 0, 1);
    checks += 6;
    if (ocup_o !== 3'd0) begin errors++; $display("FAIL mrst_ocup: got %0d exp 0", ocup_o); end
    if (free_o !== 3'd5) begin errors++; $display("FAIL mrst_free: got %0d exp 5", free_o); end
    if (rd_empty_o !== 1'b1) begin errors++; $display("FAIL mrst_empty: got %b exp 1", rd_empty_o); end
    if (rd_aempty_o !== 1'b1) begin errors++; $display("FAIL mrst_aempty: got %b exp 1", rd_aempty_o); end
    if (wr_full_o !== 1'b0) begin errors++; $display("FAIL mrst_full: got %b exp 0", wr_full_o); end
    if (wr_afull_o !== 1'b0) begin errors++; $display("FAIL mrst_afull: got %b exp 0", wr_afull_o); end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    checks += 2;
    if (ovf_o !== 1'b0) begin errors++; $display("FAIL mrst_ovf: got %b exp 0", ovf_o); end
    step(0, 0, 1);
    if (udf_o !== 1'b1) begin errors++; $display("FAIL udf_set: got %b exp 1", udf_o); end
    step(0, 0, 0, 0, 0, 1);
    checks++;
    if (udf_o !== 1'b0) begin errors++; $display("FAIL udf_clr: got %b exp 0", udf_o); end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 45,
           $urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0, $urandom_range(0, 19) == 0);
      checks += 6;
      if (ocup_o !== CW'(q.size())) begin errors++; $display("FAIL rnd_ocup: got %0d exp %0d", ocup_o, q.size()); end
      if (free_o !== CW'(SLOTS - q.size())) begin errors++; $display("FAIL rnd_free: got %0d exp %0d", free_o, SLOTS - q.size()); end
      if (rd_empty_o !== (q.size() == 0)) begin errors++; $display("FAIL rnd_empty: got %b at size %0d", rd_empty_o, q.size()); end
      if (wr_full_o !== (q.size() == SLOTS)) begin errors++; $display("FAIL rnd_full: got %b at size %0d", wr_full_o, q.size()); end
      if (wr_afull_o !== (q.size() >= 4)) begin errors++; $display("FAIL rnd_afull: got %b at size %0d", wr_afull_o, q.size()); end
      if (rd_aempty_o !== (q.size() <= 1)) begin errors++; $display("FAIL rnd_aempty: got %b at size %0d", rd_aempty_o, q.size()); end
      if (q.size() != 0) begin
        checks++;
        if (rd_data_o !== q[0]) begin errors++; $display("FAIL rnd_data: got %h exp %h", rd_data_o, q[0]); end
      end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      checks += 2;
      if (ovf_o !== ovf_m) begin errors++; $display("FAIL rnd_ovf: got %b exp %b", ovf_o, ovf_m); end
      if (udf_o !== udf_m) begin errors++; $display("FAIL rnd_udf: got %b exp %b", udf_o, udf_m); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_both();
    test_empty_both();
    test_wrap();
    test_flush();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
